serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator.sv | 183 ++++++++++++++++++
 tb/tb_serial_comparator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
//
// Purpose:
//   Compares two unsigned WIDTH-bit operands that arrive serially, MSB first,
//   one bit pair per accepted cycle. A three-state FSM (IDLE, COMPARE, DONE)
//   sequences the operation. The first differing pair fixes the decision. The
//   registered GT/EQ/LT flags update only on entry to DONE and hold their
//   value until the next DONE or a reset.
//
// Optional feature:
//   SERIAL_CMP_EARLY_EXIT_EN -- when defined, COMPARE ends right after the
//   first differing pair and the remaining bits are not consumed. Equal
//   operands still take WIDTH pairs. When undefined, WIDTH pairs are always
//   consumed.
//
// Parameters:
//   WIDTH        bits per operand (2..32)
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   start        begin a comparison (honoured in IDLE and DONE only)
//   valid        A/B carry a bit pair this cycle
//   A, B         operand bits, MSB first
//   busy         high while in COMPARE
//   done         one-cycle pulse while in DONE
//   GT, EQ, LT   registered result flags (exactly one high after a compare)
//   dbg_state_o  current FSM state (IDLE=0, COMPARE=1, DONE=2) for observation
//
// Handshake:
//   A bit pair is consumed on a rising edge where the FSM is in COMPARE and
//   valid=1. There is no back-pressure: the source presents the next pair
//   whenever it likes, and the comparator always takes it while in COMPARE.
//   A valid pair presented in the same cycle as an accepted start is ignored.
// -----------------------------------------------------------------------------
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       valid,
  input  logic       A,
  input  logic       B,
  output logic       busy,
  output logic       done,
  output logic       GT,
  output logic       EQ,
  output logic       LT,
  output logic [1:0] dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Decision so far; DEC_EQ doubles as the cleared value.
  typedef enum logic [1:0] {
    DEC_EQ = 2'd0,
    DEC_GT = 2'd1,
    DEC_LT = 2'd2
  } dec_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dec_t          dec_q, dec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;

  // Verdict of the current bit pair on its own.
  dec_t pair_dec;
  always_comb begin
    pair_dec = DEC_EQ;
    if (A && !B) begin
      pair_dec = DEC_GT;
    end else if (!A && B) begin
      pair_dec = DEC_LT;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    case (state_q)
      IDLE: begin
        // Any valid pair in this cycle is deliberately not looked at.
        if (start) begin
          state_d = COMPARE;
          cnt_d   = CNT_LOAD;
          dec_d   = DEC_EQ;
        end
      end

      COMPARE: begin
        // start is ignored here; a cycle with valid=0 changes nothing.
        if (valid) begin
          cnt_d = cnt_q - CNT_ONE;
          // Only the first differing pair may set the decision.
          if (dec_q == DEC_EQ) begin
            dec_d = pair_dec;
          end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          if ((cnt_q == CNT_ONE) || ((dec_q == DEC_EQ) && (pair_dec != DEC_EQ))) begin
`else
          if (cnt_q == CNT_ONE) begin
`endif
            state_d = DONE;
            cnt_d   = CNT_ZERO;
            // Results are captured from the decision that includes this pair.
            gt_d    = (dec_d == DEC_GT);
            eq_d    = (dec_d == DEC_EQ);
            lt_d    = (dec_d == DEC_LT);
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d = COMPARE;
          cnt_d   = CNT_LOAD;
          dec_d   = DEC_EQ;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        dec_d   = DEC_EQ;
      end
    endcase

    busy_d = (state_d == COMPARE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      dec_q   <= DEC_EQ;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign GT          = gt_q;
  assign EQ          = eq_q;
  assign LT          = lt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator
//
// Directed and randomized stimulus for serial_comparator (WIDTH=4). The
// expected results and pair counts come from integer comparisons of the
// whole operands. They do not come from a bit-level copy of the FSM. Outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_comparator;

  localparam int WIDTH = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       valid;
  logic       A;
  logic       B;
  logic       busy;
  logic       done;
  logic       GT;
  logic       EQ;
  logic       LT;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Result currently expected on {GT,EQ,LT}.
  logic [2:0] exp_res;
  // Scoreboard of results still owed by in-flight comparisons.
  logic [2:0] exp_q[$];

  serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .valid       (valid),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .GT          (GT),
    .EQ          (EQ),
    .LT          (LT),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  function automatic int model_pairs(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (a != b) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (a[i] != b[i]) return WIDTH - i;
      end
    end
`endif
    return WIDTH;
  endfunction

  // ---------------- drivers ----------------
  // Runs one comparison starting from IDLE or DONE. The task returns while
  // the DUT is in its DONE cycle.
  // stall_mode: 0 = none, 1 = random stalls, 2 = three stalls after bit 2.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int stall_mode, input string tag);
    int pairs;
    int consumed;
    int stalls;
    int cycles;
    logic stall;
    logic [2:0] new_res;

    pairs = model_pairs(a, b);
    exp_q.push_back(model_res(a, b));

    // Start cycle: the pair presented alongside start must be ignored.
    start = 1'b1;
    valid = 1'($urandom_range(0, 1));
    A     = 1'($urandom_range(0, 1));
    B     = 1'($urandom_range(0, 1));
    step();
    check({tag, " start busy"}, 32'(busy), 32'd1);
    check({tag, " start done"}, 32'(done), 32'd0);
    check({tag, " start res held"}, 32'({GT, EQ, LT}), 32'(exp_res));

    consumed = 0;
    stalls   = 0;
    cycles   = 0;
    while (consumed < pairs && cycles < 200) begin
      cycles++;
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (consumed == 2) && (stalls < 3);
        default: stall = 1'b0;
      endcase
      // start during COMPARE must have no effect.
      start = 1'($urandom_range(0, 1));
      if (stall) begin
        stalls++;
        valid = 1'b0;
        A     = 1'($urandom_range(0, 1));
        B     = 1'($urandom_range(0, 1));
      end else begin
        valid = 1'b1;
        A     = a[WIDTH-1-consumed];
        B     = b[WIDTH-1-consumed];
      end
      step();
      if (!stall) consumed++;
      if (consumed == pairs) begin
        new_res = exp_q.pop_front();
        check({tag, " done pulse"}, 32'(done), 32'd1);
        check({tag, " done busy"}, 32'(busy), 32'd0);
        check({tag, " result"}, 32'({GT, EQ, LT}), 32'(new_res));
        exp_res = new_res;
      end else begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " no done"}, 32'(done), 32'd0);
        check({tag, " res held"}, 32'({GT, EQ, LT}), 32'(exp_res));
      end
    end
    if (consumed < pairs) begin
      check({tag, " cycle budget"}, 32'(consumed), 32'(pairs));
    end
    if (stall_mode == 2) begin
      check({tag, " latency"}, 32'(cycles), 32'(pairs + stalls));
    end
    start = 1'b0;
    valid = 1'b0;
  endtask

  // One cycle with start low: from DONE or IDLE the DUT must be idle.
  task automatic idle_cycle(input string tag);
    start = 1'b0;
    valid = 1'($urandom_range(0, 1));
    A     = 1'($urandom_range(0, 1));
    B     = 1'($urandom_range(0, 1));
    step();
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
    check({tag, " idle res"}, 32'({GT, EQ, LT}), 32'(exp_res));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] ca;
    logic [WIDTH-1:0] cb;

    rst     = 1'b1;
    start   = 1'b0;
    valid   = 1'b0;
    A       = 1'b0;
    B       = 1'b0;
    exp_res = 3'b000;

    repeat (2) step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset res", 32'({GT, EQ, LT}), 32'd0);
    rst = 1'b0;

    // Start accepted on the very first edge after release.
    run_cmp(4'b1010, 4'b1010, 0, "eq");
    idle_cycle("eq");

    run_cmp(4'b0110, 4'b1000, 0, "lt_msb");
    idle_cycle("lt_msb");

    run_cmp(4'b1011, 4'b1010, 0, "gt_lsb");
    idle_cycle("gt_lsb");

    run_cmp(4'b1010, 4'b1010, 2, "eq_stall");
    idle_cycle("eq_stall");

    // Reset in the middle of a comparison.
    ca = 4'b1100;
    cb = 4'b0011;
    start = 1'b1;
    valid = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      A     = ca[WIDTH-1-i];
      B     = cb[WIDTH-1-i];
      step();
    end
    check("pre_rst busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst res", 32'({GT, EQ, LT}), 32'd0);
    exp_res = 3'b000;
    step();
    rst   = 1'b0;
    valid = 1'b1;
    A     = ca[1];
    B     = cb[1];
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst no done", 32'(done), 32'd0);
      check("post_rst busy", 32'(busy), 32'd0);
      check("post_rst res", 32'({GT, EQ, LT}), 32'd0);
    end
    valid = 1'b0;
    run_cmp(4'b0011, 4'b0011, 0, "after_rst");

    // Back-to-back: start is asserted during DONE.
    run_cmp(4'b0101, 4'b0100, 1, "b2b_1");
    run_cmp(4'b0001, 4'b1001, 1, "b2b_2");
    idle_cycle("b2b");

    // Randomized comparisons, with back-to-back or idle gaps chosen at random.
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      if ($urandom_range(0, 3) == 0) rb = ra;
      else rb = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      run_cmp(ra, rb, 1, "rand");
      if ($urandom_range(0, 1) == 1) idle_cycle("rand");
    end
    idle_cycle("final");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
